// File: rtl/afu_core_arb.sv
// Round-robin merge of per-core read and write/fence requests onto one AFU channel, with per-core read credits and tag-routed responses.
// Latency 1 cycle grant-to-request and response-to-core; almostfull or exhausted credit withholds ready. Optional perf counters: AFU_ARB_PERF_CNT_EN.
module afu_core_arb #(
  parameter int NUM_CORES = 4,
  parameter int TAG_W     = 8,
  parameter int MAX_OUTST = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_CORES-1:0]      core_rd_valid,
  input  logic [NUM_CORES*58-1:0]   core_rd_addr,
  output logic [NUM_CORES-1:0]      core_rd_ready,
  input  logic [NUM_CORES-1:0]      core_wr_valid,
  input  logic [NUM_CORES-1:0]      core_wr_fence,
  input  logic [NUM_CORES*58-1:0]   core_wr_addr,
  input  logic [NUM_CORES*512-1:0]  core_wr_data,
  output logic [NUM_CORES-1:0]      core_wr_ready,
  input  logic                      spl_tx_rd_almostfull,
  input  logic                      spl_tx_wr_almostfull,
  output logic                      cor_tx_rd_valid,
  output logic [57:0]               cor_tx_rd_addr,
  output logic [TAG_W-1:0]          cor_tx_rd_tag,
  output logic                      cor_tx_wr_valid,
  output logic                      cor_tx_fence_valid,
  output logic [57:0]               cor_tx_wr_addr,
  output logic [511:0]              cor_tx_data,
  input  logic                      io_rx_rd_valid,
  input  logic [TAG_W-1:0]          io_rx_rd_tag,
  input  logic [511:0]              io_rx_data,
  output logic [NUM_CORES-1:0]      core_rx_rd_valid,
  output logic [511:0]              core_rx_data,
  output logic                      tag_err
`ifdef AFU_ARB_PERF_CNT_EN
  ,
  output logic [NUM_CORES*32-1:0]   perf_rd_cnt
`endif
);

  localparam int PTR_W = $clog2(NUM_CORES);
  localparam int PW1   = PTR_W + 1;
  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam int CMP_W = TAG_W + 5;

  logic                 arb_en;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [CNT_W-1:0]     outst [NUM_CORES];
  logic [NUM_CORES-1:0] rd_elig;
  logic [PTR_W:0]       rd_pick;
  logic [PTR_W:0]       wr_pick;
  logic                 rd_gnt_vld;
  logic                 wr_gnt_vld;
  logic [PTR_W-1:0]     rd_gnt_idx;
  logic [PTR_W-1:0]     wr_gnt_idx;
  logic                 rsp_ok;
  logic [PTR_W-1:0]     rsp_idx;
  logic [NUM_CORES-1:0] rsp_dec;
  logic                 cnt_err;

  // Returns {found, index} of the first set request at or after ptr, wrapping.
  function automatic logic [PTR_W:0] rr_pick(input logic [NUM_CORES-1:0] req,
                                             input logic [PTR_W-1:0]     ptr);
    logic [PTR_W:0] pick;
    logic [PTR_W:0] pos;
    pick = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + PW1'(k);
      if (pos >= PW1'(NUM_CORES)) pos = pos - PW1'(NUM_CORES);
      if (req[pos[PTR_W-1:0]]) pick = {1'b1, pos[PTR_W-1:0]};
    end
    return pick;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] idx);
    return (idx == PTR_W'(NUM_CORES - 1)) ? '0 : idx + 1'b1;
  endfunction

  always_comb begin
    rd_elig = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      rd_elig[i] = core_rd_valid[i] && (outst[i] < CNT_W'(MAX_OUTST));
    end
  end

  // arb_en keeps grants off until the first clock edge after reset release.
  assign rd_pick       = rr_pick(rd_elig, rd_ptr);
  assign rd_gnt_vld    = arb_en && !spl_tx_rd_almostfull && rd_pick[PTR_W];
  assign rd_gnt_idx    = rd_pick[PTR_W-1:0];
  assign core_rd_ready = rd_gnt_vld ? (NUM_CORES'(1) << rd_gnt_idx) : '0;

  assign wr_pick       = rr_pick(core_wr_valid, wr_ptr);
  assign wr_gnt_vld    = arb_en && !spl_tx_wr_almostfull && wr_pick[PTR_W];
  assign wr_gnt_idx    = wr_pick[PTR_W-1:0];
  assign core_wr_ready = wr_gnt_vld ? (NUM_CORES'(1) << wr_gnt_idx) : '0;

  assign rsp_ok  = io_rx_rd_valid && (CMP_W'(io_rx_rd_tag) < CMP_W'(NUM_CORES));
  assign rsp_idx = io_rx_rd_tag[PTR_W-1:0];
  assign rsp_dec = rsp_ok ? (NUM_CORES'(1) << rsp_idx) : '0;

  always_comb begin
    cnt_err = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (rsp_dec[i] && !core_rd_ready[i] && (outst[i] == '0)) cnt_err = 1'b1;
    end
  end

  // A grant and a matching response in the same cycle cancel out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CORES; i++) outst[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (core_rd_ready[i] && !rsp_dec[i]) begin
          outst[i] <= outst[i] + 1'b1;
        end else if (rsp_dec[i] && !core_rd_ready[i] && (outst[i] != '0)) begin
          outst[i] <= outst[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arb_en             <= 1'b0;
      rd_ptr             <= '0;
      wr_ptr             <= '0;
      cor_tx_rd_valid    <= 1'b0;
      cor_tx_rd_addr     <= '0;
      cor_tx_rd_tag      <= '0;
      cor_tx_wr_valid    <= 1'b0;
      cor_tx_fence_valid <= 1'b0;
      cor_tx_wr_addr     <= '0;
      cor_tx_data        <= '0;
      core_rx_rd_valid   <= '0;
      core_rx_data       <= '0;
      tag_err            <= 1'b0;
    end else begin
      arb_en             <= 1'b1;
      cor_tx_rd_valid    <= rd_gnt_vld;
      cor_tx_wr_valid    <= wr_gnt_vld && !core_wr_fence[wr_gnt_idx];
      cor_tx_fence_valid <= wr_gnt_vld && core_wr_fence[wr_gnt_idx];
      core_rx_rd_valid   <= rsp_dec;
      if (rd_gnt_vld) begin
        rd_ptr         <= ptr_after(rd_gnt_idx);
        cor_tx_rd_addr <= core_rd_addr[rd_gnt_idx*58 +: 58];
        cor_tx_rd_tag  <= TAG_W'(rd_gnt_idx);
      end
      if (wr_gnt_vld) begin
        wr_ptr         <= ptr_after(wr_gnt_idx);
        cor_tx_wr_addr <= core_wr_addr[wr_gnt_idx*58 +: 58];
        cor_tx_data    <= core_wr_data[wr_gnt_idx*512 +: 512];
      end
      if (rsp_ok) core_rx_data <= io_rx_data;
      if ((io_rx_rd_valid && !rsp_ok) || cnt_err) tag_err <= 1'b1;
    end
  end

`ifdef AFU_ARB_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_rd_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (core_rd_ready[i]) perf_rd_cnt[i*32 +: 32] <= perf_rd_cnt[i*32 +: 32] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_afu_core_arb.sv
// Randomized bench for afu_core_arb: queue-based reference model feeds a scoreboard drained by an output monitor.
module tb_afu_core_arb;
  localparam int NC   = 4;
  localparam int MAXO = 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [NC-1:0]   core_rd_valid, core_rd_ready, core_wr_valid, core_wr_fence, core_wr_ready;
  logic [NC*58-1:0]  core_rd_addr, core_wr_addr;
  logic [NC*512-1:0] core_wr_data;
  logic            spl_tx_rd_almostfull, spl_tx_wr_almostfull;
  logic            cor_tx_rd_valid, cor_tx_wr_valid, cor_tx_fence_valid;
  logic [57:0]     cor_tx_rd_addr, cor_tx_wr_addr;
  logic [7:0]      cor_tx_rd_tag;
  logic [511:0]    cor_tx_data;
  logic            io_rx_rd_valid;
  logic [7:0]      io_rx_rd_tag;
  logic [511:0]    io_rx_data;
  logic [NC-1:0]   core_rx_rd_valid;
  logic [511:0]    core_rx_data;
  logic            tag_err;
`ifdef AFU_ARB_PERF_CNT_EN
  logic [NC*32-1:0] perf_rd_cnt;
`endif

  afu_core_arb #(.NUM_CORES(NC), .TAG_W(8), .MAX_OUTST(MAXO)) dut (
    .clk(clk), .reset_n(reset_n),
    .core_rd_valid(core_rd_valid), .core_rd_addr(core_rd_addr), .core_rd_ready(core_rd_ready),
    .core_wr_valid(core_wr_valid), .core_wr_fence(core_wr_fence), .core_wr_addr(core_wr_addr),
    .core_wr_data(core_wr_data), .core_wr_ready(core_wr_ready),
    .spl_tx_rd_almostfull(spl_tx_rd_almostfull), .spl_tx_wr_almostfull(spl_tx_wr_almostfull),
    .cor_tx_rd_valid(cor_tx_rd_valid), .cor_tx_rd_addr(cor_tx_rd_addr), .cor_tx_rd_tag(cor_tx_rd_tag),
    .cor_tx_wr_valid(cor_tx_wr_valid), .cor_tx_fence_valid(cor_tx_fence_valid),
    .cor_tx_wr_addr(cor_tx_wr_addr), .cor_tx_data(cor_tx_data),
    .io_rx_rd_valid(io_rx_rd_valid), .io_rx_rd_tag(io_rx_rd_tag), .io_rx_data(io_rx_data),
    .core_rx_rd_valid(core_rx_rd_valid), .core_rx_data(core_rx_data), .tag_err(tag_err)
`ifdef AFU_ARB_PERF_CNT_EN
    , .perf_rd_cnt(perf_rd_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [57:0] addr; logic [7:0] tag; } rd_e_t;
  typedef struct { int due; logic fence; logic [57:0] addr; logic [511:0] data; } wr_e_t;
  typedef struct { int due; logic [NC-1:0] oh; logic [511:0] data; } rx_e_t;

  rd_e_t rd_q[$];
  wr_e_t wr_q[$];
  rx_e_t rx_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference state: pointers, outstanding reads, sticky error, grant totals.
  int          m_rptr, m_wptr, m_err;
  int          m_outst [NC];
  int unsigned m_perf  [NC];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    m_rptr = 0; m_wptr = 0; m_err = 0;
    for (int c = 0; c < NC; c++) begin m_outst[c] = 0; m_perf[c] = 0; end
    rd_q.delete(); wr_q.delete(); rx_q.delete();
  endtask

  task automatic idle_inputs();
    core_rd_valid = '0; core_wr_valid = '0; core_wr_fence = '0;
    spl_tx_rd_almostfull = 1'b0; spl_tx_wr_almostfull = 1'b0;
    io_rx_rd_valid = 1'b0; io_rx_rd_tag = '0;
  endtask

  // One cycle of stimulus, entered at posedge+1; model evaluated at negedge.
  task automatic step(input logic [NC-1:0] rv, input logic [NC-1:0] wv, input logic [NC-1:0] wf,
                      input logic raf, input logic waf, input logic rsp_v, input logic [7:0] tag);
    int gr, gw, dec;
    rd_e_t re; wr_e_t we; rx_e_t xe;
    core_rd_valid = rv; core_wr_valid = wv; core_wr_fence = wf;
    spl_tx_rd_almostfull = raf; spl_tx_wr_almostfull = waf;
    io_rx_rd_valid = rsp_v; io_rx_rd_tag = tag; io_rx_data = rnd512();
    for (int c = 0; c < NC; c++) begin
      core_rd_addr[c*58 +: 58]  = 58'({$urandom, $urandom});
      core_wr_addr[c*58 +: 58]  = 58'({$urandom, $urandom});
      core_wr_data[c*512 +: 512] = rnd512();
    end
    @(negedge clk);
    gr = -1; gw = -1; dec = -1;
    for (int k = 0; k < NC; k++) begin
      int j;
      j = (m_rptr + k) % NC;
      if (!raf && gr < 0 && rv[j] && m_outst[j] < MAXO) gr = j;
      j = (m_wptr + k) % NC;
      if (!waf && gw < 0 && wv[j]) gw = j;
    end
    chk("rd_ready", core_rd_ready, (gr < 0) ? 0 : (1 << gr));
    chk("wr_ready", core_wr_ready, (gw < 0) ? 0 : (1 << gw));
    chk("tag_err", tag_err, m_err);
    if (gr >= 0) begin
      re.due = cyc + 1; re.addr = core_rd_addr[gr*58 +: 58]; re.tag = 8'(gr);
      rd_q.push_back(re);
      m_rptr = (gr + 1) % NC;
      m_perf[gr]++;
    end
    if (gw >= 0) begin
      we.due = cyc + 1; we.fence = wf[gw];
      we.addr = core_wr_addr[gw*58 +: 58]; we.data = core_wr_data[gw*512 +: 512];
      wr_q.push_back(we);
      m_wptr = (gw + 1) % NC;
    end
    if (rsp_v) begin
      if (tag < NC) begin
        xe.due = cyc + 1; xe.oh = NC'(1 << tag); xe.data = io_rx_data;
        rx_q.push_back(xe);
        dec = tag;
      end else m_err = 1;
    end
    if (dec >= 0 && dec != gr) begin
      if (m_outst[dec] == 0) m_err = 1;
      else m_outst[dec]--;
    end
    if (gr >= 0 && gr != dec) m_outst[gr]++;
    @(posedge clk); #1;
  endtask

  // Response to a random core that still has a read in flight, if any.
  task automatic pick_live_tag(output logic v, output logic [7:0] t);
    int s;
    v = 1'b0; t = '0; s = $urandom_range(NC - 1);
    for (int k = 0; k < NC; k++) begin
      if (!v && m_outst[(s + k) % NC] > 0) begin v = 1'b1; t = 8'((s + k) % NC); end
    end
  endtask

  task automatic drain();
    for (int c = 0; c < NC; c++) begin
      while (m_outst[c] > 0) step('0, '0, '0, 0, 0, 1, 8'(c));
    end
  endtask

  task automatic rand_phase(input int n, input bit allow_bad);
    logic v; logic [7:0] t;
    for (int i = 0; i < n; i++) begin
      pick_live_tag(v, t);
      if ($urandom_range(1) == 0) v = 1'b0;
      if (allow_bad && $urandom_range(7) == 0) begin v = 1'b1; t = 8'($urandom_range(11)); end
      step(NC'($urandom), NC'($urandom), NC'($urandom),
           $urandom_range(5) == 0, $urandom_range(5) == 0, v, t);
    end
  endtask

  // Entered at posedge+1; reset hits while registered outputs may be valid.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_rd_vld", cor_tx_rd_valid, 0);
    chk("rst_wr_vld", cor_tx_wr_valid, 0);
    chk("rst_fence_vld", cor_tx_fence_valid, 0);
    chk("rst_rx_vld", core_rx_rd_valid, 0);
    chk("rst_tag_err", tag_err, 0);
    model_reset();
    idle_inputs();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      automatic bit ev;
      automatic rd_e_t re;
      automatic wr_e_t we;
      automatic rx_e_t xe;
      ev = (rd_q.size() > 0) && (rd_q[0].due == cyc);
      chk("rd_vld", cor_tx_rd_valid, ev);
      if (ev) begin
        re = rd_q.pop_front();
        if (cor_tx_rd_valid) begin
          chk("rd_addr", cor_tx_rd_addr, re.addr);
          chk("rd_tag", cor_tx_rd_tag, re.tag);
        end
      end
      ev = (wr_q.size() > 0) && (wr_q[0].due == cyc);
      we.fence = (wr_q.size() > 0) ? wr_q[0].fence : 1'b0;
      chk("wr_vld", cor_tx_wr_valid, ev && !we.fence);
      chk("fence_vld", cor_tx_fence_valid, ev && we.fence);
      if (ev) begin
        we = wr_q.pop_front();
        if (cor_tx_wr_valid || cor_tx_fence_valid) chk("wr_addr", cor_tx_wr_addr, we.addr);
        if (cor_tx_wr_valid) chk("wr_data", cor_tx_data, we.data);
      end
      ev = (rx_q.size() > 0) && (rx_q[0].due == cyc);
      xe.oh = (ev) ? rx_q[0].oh : '0;
      chk("rx_vld", core_rx_rd_valid, xe.oh);
      if (ev) begin
        xe = rx_q.pop_front();
        if (|core_rx_rd_valid) chk("rx_data", core_rx_data, xe.data);
      end
    end
  end

  initial begin
    idle_inputs();
    core_rd_addr = '0; core_wr_addr = '0; core_wr_data = '0; io_rx_data = '0;
    model_reset();
    reset_n = 1'b0;
    #2;
    chk("init_rd_vld", cor_tx_rd_valid, 0);
    chk("init_wr_vld", cor_tx_wr_valid, 0);
    chk("init_fence_vld", cor_tx_fence_valid, 0);
    chk("init_rx_vld", core_rx_rd_valid, 0);
    chk("init_tag_err", tag_err, 0);
    chk("init_rd_ready", core_rd_ready, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // All cores request: grants rotate 0..3 until credit runs out.
    repeat (10) step('1, '0, '0, 0, 0, 0, '0);
    drain();
    // Almostfull holds the pointer for 5 cycles, then granting resumes.
    repeat (2) step('1, '0, '0, 0, 0, 0, '0);
    repeat (5) step('1, '1, '0, 1, 1, 0, '0);
    repeat (2) step('1, '1, '0, 0, 0, 0, '0);
    drain();
    // Core 1 exhausts its credit, gets skipped, then regains it.
    repeat (2) step(4'b0010, '0, '0, 0, 0, 0, '0);
    repeat (2) step(4'b0011, '0, '0, 0, 0, 0, '0);
    step(4'b0010, '0, '0, 0, 0, 1, 8'd1);
    step(4'b0010, '0, '0, 0, 0, 0, '0);
    drain();
    // Core 2 grant coincides with a tag-2 response.
    step(4'b0100, '0, '0, 0, 0, 0, '0);
    step(4'b0100, '0, '0, 0, 0, 1, 8'd2);
    drain();
    rand_phase(300, 1'b0);
    drain();
    // Out-of-range tag is dropped and latches tag_err.
    step('0, '0, '0, 0, 0, 1, 8'd9);
    repeat (4) step('0, '0, '0, 0, 0, 0, '0);
    // Fence from core 0 alternating with write from core 3, then reset mid-stream.
    repeat (3) step(4'b1111, 4'b1001, 4'b0001, 0, 0, 0, '0);
    do_reset();
    repeat (4) step('1, '0, '0, 0, 0, 0, '0);
    rand_phase(200, 1'b1);
    drain();
    repeat (3) step('0, '0, '0, 0, 0, 0, '0);
    chk("rd_q_left", 32'(rd_q.size()), 0);
    chk("wr_q_left", 32'(wr_q.size()), 0);
    chk("rx_q_left", 32'(rx_q.size()), 0);
`ifdef AFU_ARB_PERF_CNT_EN
    for (int c = 0; c < NC; c++) chk("perf_rd_cnt", perf_rd_cnt[c*32 +: 32], m_perf[c]);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
